// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note events onto oscillator voices.
// Voices are reused when free and the oldest one is stolen when all are busy.
module voice_allocator #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned AGE_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ev_valid,
    output logic                       ev_ready,
    input  logic                       ev_note_on,
    input  logic [6:0]                 ev_note,
    input  logic [1:0]                 ev_wave,
    input  logic                       cfg_we,
    input  logic [3:0]                 cfg_addr,
    input  logic [31:0]                cfg_data,
    output logic [32*NUM_VOICES-1:0]   voice_phase_incr,
    output logic [2*NUM_VOICES-1:0]    voice_wave,
    output logic [NUM_VOICES-1:0]      voice_gate,
    output logic [NUM_VOICES-1:0]      voice_retrig,
    output logic                       steal
);
    localparam int unsigned VW      = $clog2(NUM_VOICES);
    localparam int unsigned TBL     = 12;
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {IDLE, DECODE, ALLOC, COMMIT} state_t;

    state_t state, state_next;
    logic   ready_next;

    logic [31:0] base [TBL];

    logic        ev_on_q;
    logic [6:0]  ev_note_q;
    logic [1:0]  ev_wave_q;
    logic [31:0] incr_q;
    logic [VW-1:0] tgt_q;
    logic        hit_q;
    logic        evict_q;

    logic [31:0]          v_incr [NUM_VOICES];
    logic [1:0]           v_wave [NUM_VOICES];
    logic [6:0]           v_note [NUM_VOICES];
    logic [AGE_WIDTH-1:0] v_age  [NUM_VOICES];

    logic [3:0]  octave_c;
    logic [3:0]  semi_c;
    logic [31:0] incr_c;

    logic                 match_found, free_found;
    logic [VW-1:0]        match_idx, free_idx, old_idx;
    logic [AGE_WIDTH-1:0] old_age;
    logic [VW-1:0]        tgt_c;
    logic                 hit_c, evict_c;

    // State register; ev_ready is registered so it is low while in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ev_ready <= 1'b0;
        end else begin
            state    <= state_next;
            ev_ready <= ready_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_next = 1'b0;
        case (state)
            IDLE:    if (ev_valid && ev_ready) state_next = DECODE;
            DECODE:  state_next = ALLOC;
            ALLOC:   state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        ready_next = (state_next == IDLE);
    end

    // Semitone table; indices 12..15 have no storage and are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(TBL); i++) base[i] <= '0;
        end else if (cfg_we && cfg_addr < 4'd12) begin
            base[cfg_addr] <= cfg_data;
        end
    end

    // Note number to phase increment: octave 10 is the table value itself
    always_comb begin
        octave_c = 4'(ev_note_q / 7'd12);
        semi_c   = 4'(ev_note_q % 7'd12);
        incr_c   = base[semi_c] >> (4'd10 - octave_c);
    end

    // Target selection: matching note, else lowest free, else oldest
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        old_idx     = '0;
        old_age     = v_age[0];
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (voice_gate[i] && v_note[i] == ev_note_q && !match_found) begin
                match_found = 1'b1;
                match_idx   = VW'(i);
            end
            if (!voice_gate[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = VW'(i);
            end
            if (v_age[i] > old_age) begin
                old_age = v_age[i];
                old_idx = VW'(i);
            end
        end
        hit_c   = 1'b0;
        evict_c = 1'b0;
        tgt_c   = '0;
        if (ev_on_q) begin
            hit_c = 1'b1;
            if (match_found)     tgt_c = match_idx;
            else if (free_found) tgt_c = free_idx;
            else begin
                tgt_c   = old_idx;
                evict_c = 1'b1;
            end
        end else begin
            hit_c = match_found;
            tgt_c = match_idx;
        end
    end

    // Event pipeline: capture, decode result, allocation result
    always_ff @(posedge clk) begin
        if (rst) begin
            ev_on_q   <= 1'b0;
            ev_note_q <= '0;
            ev_wave_q <= '0;
            incr_q    <= '0;
            tgt_q     <= '0;
            hit_q     <= 1'b0;
            evict_q   <= 1'b0;
        end else begin
            if (state == IDLE && ev_valid && ev_ready) begin
                ev_on_q   <= ev_note_on;
                ev_note_q <= ev_note;
                ev_wave_q <= ev_wave;
            end
            if (state == DECODE) incr_q <= incr_c;
            if (state == ALLOC) begin
                tgt_q   <= tgt_c;
                hit_q   <= hit_c;
                evict_q <= evict_c;
            end
        end
    end

    // Voice bank update; note-off keeps incr/wave/age for the release tail
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                v_incr[i] <= '0;
                v_wave[i] <= '0;
                v_note[i] <= '0;
                v_age[i]  <= '0;
            end
            voice_gate   <= '0;
            voice_retrig <= '0;
            steal        <= 1'b0;
        end else begin
            voice_retrig <= '0;
            steal        <= 1'b0;
            if (state == COMMIT && hit_q) begin
                for (int i = 0; i < int'(NUM_VOICES); i++) begin
                    if (VW'(i) == tgt_q) begin
                        if (ev_on_q) begin
                            v_incr[i]       <= incr_q;
                            v_wave[i]       <= ev_wave_q;
                            v_note[i]       <= ev_note_q;
                            v_age[i]        <= '0;
                            voice_gate[i]   <= 1'b1;
                            voice_retrig[i] <= 1'b1;
                        end else begin
                            voice_gate[i] <= 1'b0;
                        end
                    end else if (ev_on_q && voice_gate[i] && v_age[i] != AGE_MAX) begin
                        v_age[i] <= v_age[i] + AGE_WIDTH'(1);
                    end
                end
                steal <= evict_q;
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_phase_incr[32*g +: 32] = v_incr[g];
        assign voice_wave[2*g +: 2]         = v_wave[g];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a queue-and-array note model predicts
// the voice bank after each event; a monitor compares at every completion.
module tb_voice_allocator;
    localparam int unsigned NV = 8;
    localparam int unsigned AW = 3;
    localparam int AGE_MAX = (1 << AW) - 1;

    typedef struct packed {
        logic [32*NV-1:0] incr;
        logic [2*NV-1:0]  wave;
        logic [NV-1:0]    gate;
        logic [NV-1:0]    retrig;
        logic             steal;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ev_valid = 1'b1;
    logic            ev_ready;
    logic            ev_note_on = 1'b1;
    logic [6:0]      ev_note = 7'd0;
    logic [1:0]      ev_wave = 2'd0;
    logic            cfg_we = 1'b0;
    logic [3:0]      cfg_addr = 4'd0;
    logic [31:0]     cfg_data = 32'd0;
    logic [32*NV-1:0] voice_phase_incr;
    logic [2*NV-1:0]  voice_wave;
    logic [NV-1:0]    voice_gate;
    logic [NV-1:0]    voice_retrig;
    logic             steal;

    voice_allocator #(.NUM_VOICES(NV), .AGE_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_note_on(ev_note_on),
        .ev_note(ev_note), .ev_wave(ev_wave),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .voice_phase_incr(voice_phase_incr), .voice_wave(voice_wave),
        .voice_gate(voice_gate), .voice_retrig(voice_retrig), .steal(steal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Reference model of the voice bank
    logic [31:0] m_base [12];
    logic [31:0] m_incr [NV];
    logic [1:0]  m_wave [NV];
    int          m_note [NV];
    bit          m_gate [NV];
    int          m_age  [NV];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 12; i++) m_base[i] = '0;
        for (int i = 0; i < int'(NV); i++) begin
            m_incr[i] = '0; m_wave[i] = '0; m_note[i] = 0; m_gate[i] = 0; m_age[i] = 0;
        end
    endfunction

    function automatic void model_cfg(input int addr, input logic [31:0] data);
        if (addr < 12) m_base[addr] = data;
    endfunction

    function automatic void model_event(input bit on, input int note, input int wave);
        exp_t e;
        int tgt = -1;
        bit stl = 0;
        int mx;
        e = '0;
        for (int i = 0; i < int'(NV); i++)
            if (m_gate[i] && m_note[i] == note) tgt = i;
        if (on) begin
            if (tgt < 0)
                for (int i = 0; i < int'(NV); i++)
                    if (!m_gate[i]) begin tgt = i; break; end
            if (tgt < 0) begin
                stl = 1;
                tgt = 0;
                mx = m_age[0];
                for (int i = 1; i < int'(NV); i++)
                    if (m_age[i] > mx) begin mx = m_age[i]; tgt = i; end
            end
            for (int i = 0; i < int'(NV); i++)
                if (i != tgt && m_gate[i] && m_age[i] < AGE_MAX) m_age[i]++;
            m_incr[tgt] = m_base[note % 12] >> (10 - note / 12);
            m_wave[tgt] = 2'(wave);
            m_note[tgt] = note;
            m_gate[tgt] = 1;
            m_age[tgt]  = 0;
            e.retrig[tgt] = 1'b1;
            e.steal = stl;
        end else if (tgt >= 0) begin
            m_gate[tgt] = 0;
        end
        for (int i = 0; i < int'(NV); i++) begin
            e.incr[32*i +: 32] = m_incr[i];
            e.wave[2*i +: 2]   = m_wave[i];
            e.gate[i]          = m_gate[i];
        end
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int guard = 0;
        tick();
        while (!ev_ready && guard < 20) begin tick(); guard++; end
        if (!ev_ready) chk("idle_timeout", 256'(ev_ready), 256'(1));
    endtask

    task automatic cfg_write(input int addr, input logic [31:0] data);
        cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_data = data;
        model_cfg(addr, data);
        tick();
        cfg_we = 1'b0;
    endtask

    // Issue one event; optional cfg write lands on the edge ending DECODE
    task automatic send(input bit on, input int note, input int wave,
                        input bit cfg, input int ca, input logic [31:0] cd);
        int guard = 0;
        tick();
        while (!ev_ready && guard < 20) begin tick(); guard++; end
        if (!ev_ready) begin
            chk("ready_timeout", 256'(ev_ready), 256'(1));
            return;
        end
        ev_valid = 1'b1; ev_note_on = on; ev_note = 7'(note); ev_wave = 2'(wave);
        model_event(on, note, wave);
        tick();
        ev_valid = 1'b0;
        if (cfg) cfg_write(ca, cd);
    endtask

    // Monitor: compares at every completion and polices pulse widths/latency
    initial begin
        bit   prev_ready = 0;
        bit   skip = 1;
        int   low_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_incr", 256'(voice_phase_incr), 256'(0));
                chk("reset_ctrl", 256'({voice_wave, voice_gate, voice_retrig, steal, ev_ready}), 256'(0));
                skip = 1; low_cnt = 0;
            end else if (ev_ready && !prev_ready) begin
                if (skip) begin
                    skip = 0;
                    chk("release_pulses", 256'({voice_retrig, steal}), 256'(0));
                end else begin
                    chk("busy_cycles", 256'(low_cnt), 256'(3));
                    if (exp_q.size() == 0) begin
                        chk("unexpected_completion", 256'(1), 256'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("voice_incr", 256'(voice_phase_incr), 256'(e.incr));
                        chk("voice_wave", 256'(voice_wave), 256'(e.wave));
                        chk("voice_gate", 256'(voice_gate), 256'(e.gate));
                        chk("voice_retrig", 256'(voice_retrig), 256'(e.retrig));
                        chk("steal", 256'(steal), 256'(e.steal));
                    end
                end
                low_cnt = 0;
            end else begin
                chk("idle_pulses", 256'({voice_retrig, steal}), 256'(0));
                if (!ev_ready) low_cnt++;
            end
            prev_ready = ev_ready;
        end
    end

    initial begin
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        ev_valid = 1'b0;
        tick();
        chk("ready_after_reset", 256'(ev_ready), 256'(1));
        repeat (3) tick();
        chk("no_change_before_event", 256'({voice_gate, voice_phase_incr}), 256'(0));

        // Basic note-on, retrigger, note-off retention, free reuse
        cfg_write(9, 32'h4000_0000);
        send(1, 69, 2, 0, 0, 0);
        wait_idle();
        chk("basic_incr0", 256'(voice_phase_incr[31:0]), 256'(32'h0200_0000));
        chk("basic_wave0", 256'(voice_wave[1:0]), 256'(2'b10));
        send(1, 69, 1, 0, 0, 0);
        wait_idle();
        chk("retrig_gate", 256'(voice_gate), 256'(8'h01));
        send(0, 69, 0, 0, 0, 0);
        wait_idle();
        chk("off_gate", 256'(voice_gate), 256'(8'h00));
        chk("off_keeps_incr", 256'(voice_phase_incr[31:0]), 256'(32'h0200_0000));
        send(1, 70, 3, 0, 0, 0);
        wait_idle();
        chk("reuse_gate", 256'(voice_gate), 256'(8'h01));

        // Octave extremes
        cfg_write(7, 32'h7FFF_FFFF);
        send(1, 127, 0, 0, 0, 0);
        wait_idle();
        chk("note127_incr", 256'(voice_phase_incr[63:32]), 256'(32'h7FFF_FFFF));
        cfg_write(0, 32'h4000_0000);
        send(1, 0, 0, 0, 0, 0);
        wait_idle();
        chk("note0_incr", 256'(voice_phase_incr[95:64]), 256'(32'h0010_0000));

        // Steal: fill all voices, then evict the oldest
        rst = 1'b1; tick(); tick(); rst = 1'b0; model_reset();
        cfg_write(0, 32'h4000_0000);
        for (int n = 60; n < 68; n++) send(1, n, n % 4, 0, 0, 0);
        send(1, 72, 1, 1, 0, 32'h1234_5678);
        wait_idle();
        chk("steal_gate", 256'(voice_gate), 256'(8'hFF));
        chk("steal_old_table", 256'(voice_phase_incr[31:0]), 256'(32'h0400_0000));
        send(0, 60, 0, 0, 0, 0);
        wait_idle();
        chk("stale_off_gate", 256'(voice_gate), 256'(8'hFF));

        // Reset in the middle of an event
        wait_idle();
        ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd69; ev_wave = 2'd2;
        tick();
        ev_valid = 1'b0;
        tick();
        rst = 1'b1; tick(); tick(); rst = 1'b0; model_reset();
        tick();
        chk("mid_reset_ready", 256'(ev_ready), 256'(1));
        chk("mid_reset_gate", 256'(voice_gate), 256'(0));
        cfg_write(9, 32'h4000_0000);
        send(1, 69, 2, 0, 0, 0);
        wait_idle();
        chk("post_reset_incr0", 256'(voice_phase_incr[31:0]), 256'(32'h0200_0000));

        // Randomized traffic around a small note pool to force matches and steals
        for (int i = 0; i < 12; i++) cfg_write(i, $urandom);
        for (int k = 0; k < 300; k++) begin
            int r = $urandom_range(0, 9);
            if (r == 0) begin
                cfg_write($urandom_range(0, 15), $urandom);
            end else begin
                send(r < 7, $urandom_range(54, 77), $urandom_range(0, 3),
                     $urandom_range(0, 4) == 0, $urandom_range(0, 15), $urandom);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            end
        end

        wait_idle();
        repeat (3) tick();
        chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic note scheduler for the synth voice bank. It accepts note-on/note-off events and converts each note number to a 32-bit phase increment using a runtime-loadable 12-entry semitone table. It assigns each note to one of NUM_VOICES oscillator voices, stealing the oldest voice when all are busy. It drives each voice's PHASE_INCR, wave_type, gate and a phase-restart pulse, and sits between the MIDI/event front end and the oscillator array.

## Interface
- NUM_VOICES, default 8: number of oscillator voices managed (2..16).
- AGE_WIDTH, default 8: width of the per-voice saturating age counter.

- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- ev_valid  in  1  event present.
- ev_ready  out  1  block can accept an event this cycle.
- ev_note_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  7  note number 0..127.
- ev_wave  in  2  waveform for note-on (00 sine, 01 square, 10 saw, 11 triangle).
- cfg_we  in  1  semitone table write strobe.
- cfg_addr  in  4  table index 0..11; writes to 12..15 are ignored.
- cfg_data  in  32  base phase increment for the octave-10 semitone.
- voice_phase_incr  out  32*NUM_VOICES  per-voice phase increment; voice i occupies bits [32i+31:32i].
- voice_wave  out  2*NUM_VOICES  per-voice wave_type.
- voice_gate  out  NUM_VOICES  1 = voice holding a note.
- voice_retrig  out  NUM_VOICES  one-cycle pulse that restarts the voice's oscillator phase.
- steal  out  1  one-cycle pulse when a note-on evicted an active voice.

## Operation
- Table: base[0..11] of 32 bits, reset to 0. A write lands on the clock edge where cfg_we=1 and can occur in any cycle. Voices already assigned are never recomputed when the table changes.
- Increment: octave = ev_note/12 (0..10), semi = ev_note%12, incr = base[semi] >> (10-octave) (logical shift).
- FSM states: IDLE → DECODE → ALLOC → COMMIT → IDLE.
  - IDLE: ev_ready=1; an event is accepted when ev_valid&&ev_ready, and the FSM moves to DECODE.
  - DECODE: compute octave, semi and incr; base[] is read in this cycle.
  - ALLOC: select the target voice.
  - COMMIT: update voice registers; return to IDLE.
- Note-on target priority:
  - (1) The voice with gate=1 and the same stored note: retrigger it.
  - (2) Otherwise, the lowest-index voice with gate=0.
  - (3) Otherwise, the voice with the largest age; ties go to the lowest index. steal pulses.
- Note-on update of the target voice: incr, wave and note are written; gate=1; age=0; retrig pulses.
- Age on note-on: every other voice with gate=1 increments its age, saturating at 2^AGE_WIDTH-1.
- Note-off: the voice with gate=1 and a matching note clears its gate. incr, wave and age are retained so the downstream release can continue. A note-off with no match is a no-op that still takes the full 4-state sequence.
- Duplicate active notes cannot exist, because a repeated note-on retriggers the existing voice.

## Timing
- Reset values:
  - All voice_* outputs, steal, the table, ages, stored notes and ev_ready are 0; the FSM is in IDLE.
  - ev_ready=1 from the first cycle after rst is deasserted.
- Accept edge E0 → DECODE after E0 → ALLOC after E1 → COMMIT after E2.
- voice registers, voice_retrig and steal change at E3; the pulses are high for exactly the cycle after E3.
- ev_ready is 0 in the cycles after E0, E1 and E2, and 1 again after E3. Maximum throughput is one event per 4 cycles.
- cfg write at the same edge as the DECODE read: the old value is used; the new value is visible from the next cycle.
- rst asserted mid-sequence: the event is dropped, all outputs clear at that edge, and no retrig or steal pulse is emitted.
- Outputs are registered; there are no combinational paths from inputs to outputs except that ev_ready depends only on state.

## Test plan
- Reset: hold rst 3 cycles with ev_valid=1 → all outputs 0 during reset; ev_ready=1 in the first cycle after release; no voice changes until an event is accepted.
- Basic note-on: load base[9]=0x40000000, send note-on 69, wave 10 → at E3 voice0 incr=0x02000000, wave=10, gate=1; retrig[0] high 1 cycle; ev_ready low for 3 cycles.
- Octave extremes: base[7]=0x7FFFFFFF with note 127 → incr 0x7FFFFFFF; base[0]=0x40000000 with note 0 → incr 0x00100000.
- Retrigger and free reuse:
  - note-on 69 twice → voice0 retriggered, gate1 stays 0.
  - note-off 69 → gate0=0, incr0 still 0x02000000.
  - note-on 70 → lands in voice0.
- Steal: note-on 60..67 fill voices 0..7; then note-on 72 → voice0 replaced, steal pulse, retrig[0]; a subsequent note-off 60 changes nothing.
- Reset mid-event: accept note-on 69, assert rst after E1 → all outputs 0, no retrig/steal pulse; next event after release behaves as from reset.
